key_debug_gate: RTL and testbench



---
 rtl/secure_pkg.sv | 32 +++
 rtl/session_timer.sv | 39 +++
 rtl/key_debug_gate.sv | 181 ++++++++++++++++++
 tb/tb_key_debug_gate.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_pkg.sv
// -----------------------------------------------------------------------------
// secure_pkg
// Shared definitions for the key/debug gatekeeper in front of the secure core.
//   gate_state_t   : gatekeeper FSM states
//   KEY_W          : width of the secret key and of the authentication token
//   DBG_LVL_W      : width of a debug level
//   PROD_MAX_LEVEL : highest level grantable in production lifecycle; levels
//                    above it also force a key zeroize before the grant
//   level_allowed(): lifecycle/level part of the request check
// -----------------------------------------------------------------------------
package secure_pkg;

  localparam int KEY_W          = 32;
  localparam int DBG_LVL_W      = 4;
  localparam int PROD_MAX_LEVEL = 2;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ZEROIZE,
    DEBUG,
    LOCKED
  } gate_state_t;

  // Level 0 is never a meaningful request; production parts cap the level.
  function automatic logic level_allowed(input logic [DBG_LVL_W-1:0] level,
                                         input logic                 lc_prod);
    return (level != '0) &&
           !(lc_prod && (level > DBG_LVL_W'(PROD_MAX_LEVEL)));
  endfunction

endpackage

// File: rtl/session_timer.sv
// -----------------------------------------------------------------------------
// session_timer
// Loadable down-counter bounding the length of a debug session.
//   clk     : clock
//   rst_n   : synchronous active-low reset
//   load    : load CYCLES-1 (asserted on the edge that enters a session)
//   clear   : force the count to zero (held while no session is active)
//   expired : count has reached zero; the session ends on the next edge
// The count stops at zero rather than wrapping.
// -----------------------------------------------------------------------------
module session_timer #(
  parameter int CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(CYCLES - 1);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/key_debug_gate.sv
// -----------------------------------------------------------------------------
// key_debug_gate
// Gatekeeper holding the secure core's secret key and driving its debug level.
// Debug is granted only after token authentication, with a bounded number of
// failed attempts (then permanent lockout until reset) and a bounded session
// length. Grants above PROD_MAX_LEVEL zeroize the key one cycle before the
// level rises, so a high debug level never coexists with the real key.
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   key_in/key_valid      : key load request, accepted when key_ready is high
//   key_ready             : high only in IDLE
//   dbg_req_valid/_ready  : debug unlock request handshake (ready only in IDLE)
//   dbg_req_level         : requested level, latched with the request
//   dbg_token             : authentication token, latched with the request
//   dbg_exit              : end the current debug session
//   lc_prod               : production lifecycle, caps level at PROD_MAX_LEVEL
//   secret_key            : key to the secure core (registered)
//   debug_level           : level to the secure core (registered)
//   key_loaded            : secret_key holds a loaded, non-zeroized key
//   auth_fail             : one-cycle pulse per rejected request
//   locked_out            : lockout active
// -----------------------------------------------------------------------------
module key_debug_gate
  import secure_pkg::*;
#(
  parameter logic [KEY_W-1:0] UNLOCK_TOKEN   = 32'hA5C3_0F1E,
  parameter int               MAX_FAILS      = 3,
  parameter int               SESSION_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [KEY_W-1:0]     key_in,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic                 dbg_req_valid,
  output logic                 dbg_req_ready,
  input  logic [DBG_LVL_W-1:0] dbg_req_level,
  input  logic [KEY_W-1:0]     dbg_token,
  input  logic                 dbg_exit,
  input  logic                 lc_prod,
  output logic [KEY_W-1:0]     secret_key,
  output logic [DBG_LVL_W-1:0] debug_level,
  output logic                 key_loaded,
  output logic                 auth_fail,
  output logic                 locked_out
);

  localparam int FAIL_W = $clog2(MAX_FAILS + 1);

  gate_state_t          state, next_state;
  logic [KEY_W-1:0]     key_reg;
  logic [KEY_W-1:0]     req_token;
  logic [DBG_LVL_W-1:0] req_level;
  logic [FAIL_W-1:0]    fail_cnt;
  logic [FAIL_W-1:0]    fail_next;

  logic key_hs, req_hs;
  logic req_ok, req_high, last_fail;
  logic enter_debug, leave_debug, zeroize_now;
  logic timer_expired;

  // ---------------------------------------------------------------------------
  // Request evaluation (only meaningful while in CHECK)
  // ---------------------------------------------------------------------------
  assign req_ok    = (req_token == UNLOCK_TOKEN) && level_allowed(req_level, lc_prod);
  assign req_high  = (req_level > DBG_LVL_W'(PROD_MAX_LEVEL));
  assign fail_next = (fail_cnt == FAIL_W'(MAX_FAILS)) ? fail_cnt : fail_cnt + 1'b1;
  assign last_fail = (fail_next == FAIL_W'(MAX_FAILS));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    next_state = state;
    unique case (state)
      IDLE:    if (req_hs) next_state = CHECK;
      CHECK: begin
        if (req_ok)         next_state = req_high ? ZEROIZE : DEBUG;
        else if (last_fail) next_state = LOCKED;
        else                next_state = IDLE;
      end
      ZEROIZE: next_state = DEBUG;
      // dbg_exit and expiry both end the session on the next edge.
      DEBUG:   if (dbg_exit || timer_expired) next_state = IDLE;
      LOCKED:  next_state = LOCKED;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / strobe decode
  // ---------------------------------------------------------------------------
  always_comb begin
    key_ready     = (state == IDLE);
    dbg_req_ready = (state == IDLE);
    key_hs        = key_valid && key_ready;
    req_hs        = dbg_req_valid && dbg_req_ready;
    enter_debug   = (state != DEBUG) && (next_state == DEBUG);
    leave_debug   = (state == DEBUG) && (next_state != DEBUG);
    // The key is cleared on the edge into ZEROIZE so it already reads zero
    // during the cycle before debug_level rises.
    zeroize_now   = (state == CHECK) && req_ok && req_high;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_reg     <= '0;
      key_loaded  <= 1'b0;
      req_level   <= '0;
      req_token   <= '0;
      fail_cnt    <= '0;
      debug_level <= '0;
      auth_fail   <= 1'b0;
      locked_out  <= 1'b0;
    end else begin
      auth_fail <= 1'b0;

      if (key_hs) begin
        key_reg    <= key_in;
        key_loaded <= 1'b1;
      end

      if (req_hs) begin
        req_level <= dbg_req_level;
        req_token <= dbg_token;
      end

      if (state == CHECK) begin
        if (req_ok) begin
          fail_cnt <= '0;
        end else begin
          fail_cnt  <= fail_next;
          auth_fail <= 1'b1;
          if (last_fail) locked_out <= 1'b1;
        end
      end

      if (zeroize_now) begin
        key_reg    <= '0;
        key_loaded <= 1'b0;
      end

      if (enter_debug) debug_level <= req_level;
      if (leave_debug) debug_level <= '0;
    end
  end

  assign secret_key = key_reg;

  // ---------------------------------------------------------------------------
  // Session length bound
  // ---------------------------------------------------------------------------
  session_timer #(
    .CYCLES (SESSION_CYCLES)
  ) u_session_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (enter_debug),
    .clear   ((state != DEBUG) && !enter_debug),
    .expired (timer_expired)
  );

endmodule

// File: tb/tb_key_debug_gate.sv
// -----------------------------------------------------------------------------
// tb_key_debug_gate
// Directed bench for key_debug_gate (SESSION_CYCLES = 8). Stimulus pushes the
// full expected output vector for a given cycle into a scoreboard queue; an
// independent monitor samples the outputs on the falling edge and pops and
// compares every entry due for that cycle.
// Output vector layout: {key_ready, dbg_req_ready, locked_out, auth_fail,
//                        key_loaded, debug_level[3:0], secret_key[31:0]}
// -----------------------------------------------------------------------------
module tb_key_debug_gate;

  localparam logic [31:0] TOKEN = 32'hA5C3_0F1E;
  localparam logic [31:0] BAD   = 32'h0BAD_0BAD;
  localparam logic [31:0] K1    = 32'h1234_5678;
  localparam logic [31:0] K2    = 32'hCAFE_F00D;
  localparam logic [31:0] K3    = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] key_in = '0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic        dbg_req_valid = 1'b0;
  logic        dbg_req_ready;
  logic [3:0]  dbg_req_level = '0;
  logic [31:0] dbg_token = '0;
  logic        dbg_exit = 1'b0;
  logic        lc_prod = 1'b0;
  logic [31:0] secret_key;
  logic [3:0]  debug_level;
  logic        key_loaded;
  logic        auth_fail;
  logic        locked_out;

  key_debug_gate #(
    .UNLOCK_TOKEN   (TOKEN),
    .MAX_FAILS      (3),
    .SESSION_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_in        (key_in),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_req_level (dbg_req_level),
    .dbg_token     (dbg_token),
    .dbg_exit      (dbg_exit),
    .lc_prod       (lc_prod),
    .secret_key    (secret_key),
    .debug_level   (debug_level),
    .key_loaded    (key_loaded),
    .auth_fail     (auth_fail),
    .locked_out    (locked_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          at;
    string       name;
    logic [40:0] vec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, got, want);
    end
  endtask

  function automatic logic [40:0] pack_out(input logic rdy, input logic lo, input logic af,
                                           input logic kl, input logic [3:0] lvl,
                                           input logic [31:0] key);
    return {rdy, rdy, lo, af, kl, lvl, key};
  endfunction

  // Expected outputs dt cycles from now.
  task automatic expect_out(input int dt, input string name, input logic [31:0] key,
                            input logic [3:0] lvl, input logic kl, input logic af,
                            input logic lo, input logic rdy);
    exp_t e;
    e.at   = cyc + dt;
    e.name = name;
    e.vec  = pack_out(rdy, lo, af, kl, lvl, key);
    sb.push_back(e);
  endtask

  // Monitor: compare every scoreboard entry due this cycle.
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      check(mon_e.name,
            64'({key_ready, dbg_req_ready, locked_out, auth_fail, key_loaded,
                 debug_level, secret_key}),
            64'(mon_e.vec));
    end
    if (debug_level > 4'd2) check("invariant_high_level_key_zero", 64'(secret_key), 64'd0);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_key(input logic [31:0] k);
    expect_out(1, "key_load", k, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    key_in    = k;
    key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
  endtask

  task automatic request(input logic [3:0] level, input logic [31:0] token);
    dbg_req_level = level;
    dbg_token     = token;
    dbg_req_valid = 1'b1;
    step(1);
    dbg_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    // Reset
    step(1);
    expect_out(1, "reset_values", '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    rst_n = 1'b1;
    expect_out(1, "idle_after_reset", '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);

    // Key load
    load_key(K1);

    // Level 1 grant keeps key, dbg_exit drops level next edge
    expect_out(1, "l1_check", K1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(2, "l1_grant", K1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    request(4'd1, TOKEN);
    step(1);
    dbg_exit = 1'b1;
    expect_out(1, "l1_exit", K1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    dbg_exit = 1'b0;

    // Level 4 grant: key zero one cycle before level rises
    expect_out(1, "l4_check",   K1,  4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(2, "l4_zeroize", '0,  4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(3, "l4_grant",   '0,  4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    request(4'd4, TOKEN);
    step(2);
    dbg_exit = 1'b1;
    expect_out(1, "l4_exit", '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    dbg_exit = 1'b0;

    // Production part: level 3 rejected even with correct token
    lc_prod = 1'b1;
    expect_out(1, "prod_l3_check",  '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(2, "prod_l3_reject", '0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_out(3, "prod_fail_pulse_end", '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    request(4'd3, TOKEN);
    step(1);
    check("fail_cnt_after_prod_reject", 64'(dut.fail_cnt), 64'd1);
    step(1);

    // Level 0 is always rejected
    expect_out(1, "l0_check",  '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out(2, "l0_reject", '0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    request(4'd0, TOKEN);
    step(1);
    check("fail_cnt_after_l0_reject", 64'(dut.fail_cnt), 64'd2);
    step(1);

    // Level 2 grant in production, session expires after 8 cycles
    load_key(K2);
    expect_out(1,  "l2_check",      K2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(2,  "l2_grant",      K2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(9,  "l2_last_cycle", K2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(10, "l2_expired",    K2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    request(4'd2, TOKEN);
    step(1);
    check("fail_cnt_cleared_on_grant", 64'(dut.fail_cnt), 64'd0);
    step(8);
    lc_prod = 1'b0;

    // Three wrong tokens -> lockout on the third auth_fail
    for (int i = 0; i < 3; i++) begin
      expect_out(1, "bad_token_check",  K2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out(2, "bad_token_reject", K2, 4'd0, 1'b1, 1'b1, (i == 2), (i != 2));
      request(4'd1, BAD);
      step(1);
    end

    // Locked: correct token and key load both ignored
    expect_out(1, "locked_steady",        K2, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_out(2, "locked_ignores_req",   K2, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_out(3, "locked_ignores_key",   K2, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    dbg_req_level = 4'd1;
    dbg_token     = TOKEN;
    dbg_req_valid = 1'b1;
    key_in        = K3;
    key_valid     = 1'b1;
    step(3);
    dbg_req_valid = 1'b0;
    key_valid     = 1'b0;

    // Reset clears lockout
    rst_n = 1'b0;
    expect_out(1, "reset_from_locked", '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    rst_n = 1'b1;

    // Reset in the middle of a session
    load_key(K1);
    expect_out(1, "mid_check", K1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out(2, "mid_grant", K1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    request(4'd1, TOKEN);
    step(3);
    rst_n = 1'b0;
    expect_out(1, "reset_mid_session", '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);
    rst_n = 1'b1;
    expect_out(1, "idle_after_mid_reset", '0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1);

    step(2);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
